mem_read_sequencer: RTL

- Downstream consumer and enable-driver for the fixed/erasable memory dual 4-bit tri-state buffer pair.
- Strobes a memory read and sequences the low-byte and high-byte buffer output enables onto a shared 8-bit pulled-up bus.
- Captures both bytes, assembles a 16-bit AGC word (bit 15 = parity), checks odd parity, and presents the word to the CPU side with a valid/ack handshake.

---
 rtl/mem_read_sequencer_pkg.sv | 27 ++
 rtl/mem_read_sequencer_if.sv | 30 +++
 rtl/mem_read_sequencer_parity.sv | 13 +
 rtl/mem_read_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_read_sequencer_pkg.sv
// Shared definitions for the AGC memory read path: FSM encoding, word/address
// geometry and the value a pulled-up, undriven buffer bus reads back as.
package mem_pkg;

  localparam int WORD_W   = 16;
  localparam int PAR_BIT  = 15;
  localparam int ADDR_W   = 12;
  localparam int BYTE_W   = 8;
  localparam int CNT_W    = 4;

  localparam logic [BYTE_W-1:0] IDLE_BUS = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LO,
    ST_GAP,
    ST_HI,
    ST_DONE
  } state_e;

  // Counter reload value for a phase lasting `cycles` clocks after entry.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem_read_sequencer_if.sv
// Request/bus/handshake bundle between the read sequencer, the buffer pair
// and the CPU-side consumer.
interface mem_read_sequencer_if;
  import mem_pkg::*;

  logic                REQ;
  logic [ADDR_W-1:0]   ADDR;
  logic                ACK;
  logic [BYTE_W-1:0]   BUS_IN;
  logic                RD_;
  logic [ADDR_W-1:0]   MEM_ADDR;
  logic                OE_LO_;
  logic                OE_HI_;
  logic                READY;
  logic                VALID;
  logic [WORD_W-1:0]   WORD;
  logic                PAR_ERR;

  // The sequencer drives the memory strobes and the CPU-facing word.
  modport master (
    input  REQ, ADDR, ACK, BUS_IN,
    output RD_, MEM_ADDR, OE_LO_, OE_HI_, READY, VALID, WORD, PAR_ERR
  );

  modport slave (
    output REQ, ADDR, ACK, BUS_IN,
    input  RD_, MEM_ADDR, OE_LO_, OE_HI_, READY, VALID, WORD, PAR_ERR
  );

endinterface

// File: rtl/mem_read_sequencer_parity.sv
// Combinational odd-parity checker for a 16-bit AGC word (bit 15 is parity).
// Shared between the read path and the write path.
module agc_parity_check
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              err
);

  // A valid AGC word has an odd number of ones.
  assign err = ~^word;

endmodule

// File: rtl/mem_read_sequencer.sv
// Memory read sequencer: strobes RD_, enables the low then high byte buffer
// onto the shared bus with a turnaround gap, assembles and parity-checks the word.
module mem_read_sequencer
  import mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST_,
  mem_read_sequencer_if.master  bus
);

  localparam logic [CNT_W-1:0] ACC_LOAD = cnt_load(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] SET_LOAD = cnt_load(SETTLE_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_n_q, rd_n_d;
  logic                oe_lo_n_q, oe_lo_n_d;
  logic                oe_hi_n_q, oe_hi_n_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                par_err_q, par_err_d;
  logic                par_err_w;

  // Parity is evaluated on the word as it will look once the high byte lands.
  agc_parity_check u_parity (
    .word ({bus.BUS_IN, word_q[BYTE_W-1:0]}),
    .err  (par_err_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_n_d    = rd_n_q;
    oe_lo_n_d = oe_lo_n_q;
    oe_hi_n_d = oe_hi_n_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    word_d    = word_q;
    par_err_d = par_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.REQ) begin
          state_d = ST_ACCESS;
          cnt_d   = ACC_LOAD;
          addr_d  = bus.ADDR;
          rd_n_d  = 1'b0;
          ready_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d   = ST_LO;
          cnt_d     = SET_LOAD;
          oe_lo_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LO: begin
        if (cnt_q == '0) begin
          state_d              = ST_GAP;
          cnt_d                = '0;
          oe_lo_n_d            = 1'b1;
          word_d[BYTE_W-1:0]   = bus.BUS_IN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Single clock with both buffers released so they never fight on the bus.
      ST_GAP: begin
        state_d   = ST_HI;
        cnt_d     = SET_LOAD;
        oe_hi_n_d = 1'b0;
      end
      ST_HI: begin
        if (cnt_q == '0) begin
          state_d                 = ST_DONE;
          cnt_d                   = '0;
          oe_hi_n_d               = 1'b1;
          rd_n_d                  = 1'b1;
          valid_d                 = 1'b1;
          word_d[WORD_W-1:BYTE_W] = bus.BUS_IN;
          par_err_d               = par_err_w;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // A simultaneous REQ is dropped here; it must be re-presented once READY is seen.
      ST_DONE: begin
        if (bus.ACK) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        rd_n_d    = 1'b1;
        oe_lo_n_d = 1'b1;
        oe_hi_n_d = 1'b1;
        ready_d   = 1'b1;
        valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_n_q    <= 1'b1;
      oe_lo_n_q <= 1'b1;
      oe_hi_n_q <= 1'b1;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      word_q    <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_n_q    <= rd_n_d;
      oe_lo_n_q <= oe_lo_n_d;
      oe_hi_n_q <= oe_hi_n_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      word_q    <= word_d;
      par_err_q <= par_err_d;
    end
  end

  assign bus.RD_      = rd_n_q;
  assign bus.MEM_ADDR = addr_q;
  assign bus.OE_LO_   = oe_lo_n_q;
  assign bus.OE_HI_   = oe_hi_n_q;
  assign bus.READY    = ready_q;
  assign bus.VALID    = valid_q;
  assign bus.WORD     = word_q;
  assign bus.PAR_ERR  = par_err_q;

endmodule
